gshare_predictor: RTL

Parametrised conditional-branch direction predictor for the fetch pipeline. It indexes a PHT of saturating counters with a gshare hash, PC XOR global history. It keeps a speculative GHR and repairs it from a commit-stage snapshot on misprediction. An init FSM clears the PHT after reset. Output feeds the BPU next-PC select alongside BTB hit/target.

---
 rtl/gshare_predictor.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// Gshare conditional-branch direction predictor: PHT of saturating counters indexed by PC ^ GHR.
// Optional macro GSHARE_BYPASS_EN forwards a same-cycle counter update into the lookup response.
module gshare_predictor #(
    parameter int GHR_WIDTH     = 8,
    parameter int PHT_IDX_WIDTH = 8,
    parameter int CTR_WIDTH     = 2,
    parameter int CTR_INIT      = 2**(CTR_WIDTH-1)-1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     req_rdy,
    input  logic                     req_vld,
    input  logic [31:0]              req_pc,
    output logic                     resp_vld,
    output logic                     resp_taken,
    output logic [CTR_WIDTH-1:0]     resp_ctr,
    output logic [PHT_IDX_WIDTH-1:0] resp_idx,
    output logic [GHR_WIDTH-1:0]     resp_ghr,
    input  logic                     spec_vld,
    input  logic                     spec_taken,
    input  logic                     upd_vld,
    input  logic [PHT_IDX_WIDTH-1:0] upd_idx,
    input  logic                     upd_taken,
    input  logic                     upd_mispredict,
    input  logic [GHR_WIDTH-1:0]     upd_ghr
);

    localparam int PHT_ENTRIES = 2**PHT_IDX_WIDTH;
    localparam logic [CTR_WIDTH-1:0]     CTR_MAX      = '1;
    localparam logic [CTR_WIDTH-1:0]     CTR_INIT_VAL = CTR_WIDTH'(CTR_INIT);
    localparam logic [PHT_IDX_WIDTH-1:0] LAST_IDX     = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PHT_IDX_WIDTH-1:0] init_cnt;
    logic [CTR_WIDTH-1:0]     pht [PHT_ENTRIES];
    logic [GHR_WIDTH-1:0]     ghr;

    logic                     pht_we;
    logic [PHT_IDX_WIDTH-1:0] pht_waddr;
    logic [CTR_WIDTH-1:0]     pht_wdata;
    logic [CTR_WIDTH-1:0]     upd_ctr_cur;
    logic [CTR_WIDTH-1:0]     upd_ctr_next;
    logic [PHT_IDX_WIDTH-1:0] ghr_ext;
    logic [PHT_IDX_WIDTH-1:0] lookup_idx;
    logic [CTR_WIDTH-1:0]     lookup_ctr;
    logic                     req_acc;

    // PC word-address bits above the index and the oldest upd_ghr bit are never hashed.
    logic unused_inputs;
    assign unused_inputs = ^{req_pc[31:PHT_IDX_WIDTH+2], req_pc[1:0], upd_ghr[GHR_WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + PHT_IDX_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (init_cnt == LAST_IDX) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_INIT;
        endcase
    end

    // The single PHT write port belongs to the clear sweep in INIT and to commit updates in RUN.
    always_comb begin
        req_rdy   = 1'b0;
        pht_we    = 1'b0;
        pht_waddr = upd_idx;
        pht_wdata = upd_ctr_next;
        case (state)
            ST_INIT: begin
                pht_we    = 1'b1;
                pht_waddr = init_cnt;
                pht_wdata = CTR_INIT_VAL;
            end
            ST_RUN: begin
                req_rdy = 1'b1;
                pht_we  = upd_vld;
            end
            default: begin
                req_rdy = 1'b0;
            end
        endcase
    end

    always_comb begin
        upd_ctr_cur  = pht[upd_idx];
        upd_ctr_next = upd_ctr_cur;
        if (upd_taken) begin
            if (upd_ctr_cur != CTR_MAX) upd_ctr_next = upd_ctr_cur + CTR_WIDTH'(1);
        end else begin
            if (upd_ctr_cur != '0) upd_ctr_next = upd_ctr_cur - CTR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht[pht_waddr] <= pht_wdata;
        end
    end

    assign ghr_ext    = PHT_IDX_WIDTH'(ghr);
    assign lookup_idx = req_pc[PHT_IDX_WIDTH+1:2] ^ ghr_ext;
    assign req_acc    = req_vld & req_rdy;

    always_comb begin
        lookup_ctr = pht[lookup_idx];
`ifdef GSHARE_BYPASS_EN
        if (state == ST_RUN && upd_vld && upd_idx == lookup_idx) begin
            lookup_ctr = upd_ctr_next;
        end
`endif
    end

    // A mispredict repair overrides any speculative push issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (state == ST_RUN) begin
            if (upd_vld && upd_mispredict) begin
                ghr <= {upd_ghr[GHR_WIDTH-2:0], upd_taken};
            end else if (spec_vld) begin
                ghr <= {ghr[GHR_WIDTH-2:0], spec_taken};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_vld   <= 1'b0;
            resp_taken <= 1'b0;
            resp_ctr   <= '0;
            resp_idx   <= '0;
            resp_ghr   <= '0;
        end else begin
            resp_vld <= req_acc;
            if (req_acc) begin
                resp_taken <= lookup_ctr[CTR_WIDTH-1];
                resp_ctr   <= lookup_ctr;
                resp_idx   <= lookup_idx;
                resp_ghr   <= ghr;
            end
        end
    end

endmodule
